serial_add: RTL and testbench

SERIAL_ADD -- requirements
Module: serial_add

---
 rtl/serial_add.sv | 119 +++++++++++
 tb/tb_serial_add.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add.sv
// Bit-serial unsigned adder: adds two j-bit operands one bit per clock, LSB first.
// Latency: start accepted at edge E0, done pulses during the cycle after edge E0+j.
// Backpressure: start is ignored while busy. Optional carry-in port via macro SERIAL_ADD_CIN_EN.
module serial_add #(
  parameter int j = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [j-1:0] val0,
  input  logic [j-1:0] val1,
`ifdef SERIAL_ADD_CIN_EN
  input  logic         cin,
`endif
  output logic         busy,
  output logic         done,
  output logic [j-1:0] sum,
  output logic         carry
);

  localparam int CW = (j > 1) ? $clog2(j) : 1;
  localparam logic [CW-1:0] LAST = CW'(j - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [j-1:0]    a_q, a_d;
  logic [j-1:0]    b_q, b_d;
  // Only j-1 result bits need storage; the final bit goes straight into sum.
  logic [j-2:0]    res_q, res_d;
  logic            c_q, c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [j-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;

  logic            cin_s;
  logic            bit_s;
  logic            c_nxt;

`ifdef SERIAL_ADD_CIN_EN
  assign cin_s = cin;
`else
  assign cin_s = 1'b0;
`endif

  // Full-adder slice on the current LSBs of the operand shift registers.
  assign bit_s = a_q[0] ^ b_q[0] ^ c_q;
  assign c_nxt = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

  assign sum   = sum_q;
  assign carry = carry_q;

  // Next-state, datapath and status outputs; every target defaults to hold.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = val0;
          b_d     = val1;
          c_d     = cin_s;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Final bit: publish the complete result; sum/carry stay frozen otherwise.
          sum_d   = {bit_s, res_q};
          carry_d = c_nxt;
          state_d = DONE;
        end else begin
          res_d = {bit_s, res_q[j-2:1]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add: cycle model plus directed literal checks.
// Inputs change 2 time units after a rising edge; outputs are sampled 1 unit after it.
// Define SERIAL_ADD_CIN_EN for both RTL and bench to exercise the carry-in port.
module tb_serial_add;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] val0, val1;
  logic       cin;
  logic       busy, done, carry;
  logic [3:0] sum;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Model state: cycles of work remaining, pending result, expected outputs.
  int         m_pend = 0;
  logic [4:0] m_res = '0;
  logic       m_done = 1'b0;
  logic [3:0] m_sum = '0;
  logic       m_carry = 1'b0;

  always #5 clk = ~clk;

  serial_add #(.j(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .val0  (val0),
    .val1  (val1),
`ifdef SERIAL_ADD_CIN_EN
    .cin   (cin),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted request yields its arithmetic sum after 4 busy cycles.
  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0; m_done = 1'b0; m_sum = '0; m_carry = 1'b0;
    end else if (m_pend == 1) begin
      m_pend = 0; m_done = 1'b1; {m_carry, m_sum} = m_res;
    end else if (m_pend > 1) begin
      m_pend--; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_pend = 4;
        m_res  = {1'b0, val0} + {1'b0, val1};
`ifdef SERIAL_ADD_CIN_EN
        m_res  = m_res + {4'b0, cin};
`endif
      end
    end
    #1;
    if (done) done_cnt++;
    chk("model busy",  int'(busy),  int'(m_pend != 0));
    chk("model done",  int'(done),  int'(m_done));
    chk("model sum",   int'(sum),   int'(m_sum));
    chk("model carry", int'(carry), int'(m_carry));
  end

  // One start pulse; checks busy for 4 cycles then done and result literals.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input int es, input int ec, input string nm);
    @(posedge clk); #2;
    start = 1'b1; val0 = a; val1 = b; cin = c;
    @(posedge clk); #2;
    start = 1'b0;
    chk({nm, " busy0"}, int'(busy), 1);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk({nm, " busy"}, int'(busy), 1);
      chk({nm, " early done"}, int'(done), 0);
    end
    @(posedge clk); #1;
    chk({nm, " done"}, int'(done), 1);
    chk({nm, " busy end"}, int'(busy), 0);
    chk({nm, " sum"}, int'(sum), es);
    chk({nm, " carry"}, int'(carry), ec);
  endtask

  initial begin
    int dc0;
    rst = 1'b1; start = 1'b0; val0 = '0; val1 = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset sum", int'(sum), 0);
    chk("reset carry", int'(carry), 0);
    #1 rst = 1'b0;

    do_op(4'd5,  4'd7,  1'b0, 12, 0, "5+7");
    do_op(4'd9,  4'd8,  1'b0, 1,  1, "9+8");
    do_op(4'd15, 4'd15, 1'b0, 14, 1, "15+15");
    do_op(4'd0,  4'd0,  1'b0, 0,  0, "0+0");

    // Start during RUN must be ignored.
    @(posedge clk); #2;
    start = 1'b1; val0 = 4'd3; val1 = 4'd4;
    @(posedge clk); #2;                       // E0 accept
    start = 1'b0;
    @(posedge clk); #2;                       // E1
    start = 1'b1; val0 = 4'd10; val1 = 4'd10;
    dc0 = done_cnt;
    @(posedge clk); #2;                       // E2 (in RUN)
    start = 1'b0;
    @(posedge clk);                           // E3
    @(posedge clk); #1;                       // E4
    chk("ignore done", int'(done), 1);
    chk("ignore sum", int'(sum), 7);
    chk("ignore carry", int'(carry), 0);
    repeat (4) @(posedge clk);
    #3;
    chk("ignore done count", done_cnt - dc0, 1);
    chk("ignore idle busy", int'(busy), 0);

    // Start held high: done every 5 cycles, operands changed during RUN/DONE.
    @(posedge clk); #2;
    start = 1'b1; val0 = 4'd1; val1 = 4'd2;
    @(posedge clk); #2;                       // E0
    val0 = 4'd8; val1 = 4'd8;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;                       // E4
    chk("b2b1 done", int'(done), 1);
    chk("b2b1 sum", int'(sum), 3);
    chk("b2b1 carry", int'(carry), 0);
    @(posedge clk); #1;                       // E5 accept 8+8
    chk("b2b1 busy", int'(busy), 1);
    #1 val0 = 4'd15; val1 = 4'd1;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;                       // E9
    chk("b2b2 done", int'(done), 1);
    chk("b2b2 sum", int'(sum), 0);
    chk("b2b2 carry", int'(carry), 1);
    @(posedge clk); #1;                       // E10 accept 15+1
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;                       // E14
    chk("b2b3 done", int'(done), 1);
    chk("b2b3 sum", int'(sum), 0);
    chk("b2b3 carry", int'(carry), 1);

    // Reset in the middle of RUN aborts; next start right after release.
    @(posedge clk); #2;
    start = 1'b1; val0 = 4'd6; val1 = 4'd6;
    @(posedge clk); #2;                       // E0
    start = 1'b0;
    @(posedge clk); #2;                       // E1
    rst = 1'b1;
    @(posedge clk); #1;                       // E2 reset
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort sum", int'(sum), 0);
    chk("abort carry", int'(carry), 0);
    #1;
    rst = 1'b0; start = 1'b1; val0 = 4'd2; val1 = 4'd2;
    @(posedge clk); #2;                       // accept on first edge out of reset
    start = 1'b0;
    chk("post-reset busy", int'(busy), 1);
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    chk("post-reset done", int'(done), 1);
    chk("post-reset sum", int'(sum), 4);
    chk("post-reset carry", int'(carry), 0);

`ifdef SERIAL_ADD_CIN_EN
    do_op(4'd7, 4'd8, 1'b1, 0,  1, "7+8+1");
    do_op(4'd7, 4'd8, 1'b0, 15, 0, "7+8+0");
`endif

    repeat (3) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
